// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, RV32I field constants and the EX bundle type
package alu_pkg;

   localparam int XLEN = 32;
   localparam logic RESET_PC_INVALID = 1'b1;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_SLL  = 4'h2;
   localparam logic [3:0] ALU_XOR  = 4'h3;
   localparam logic [3:0] ALU_SRL  = 4'h4;
   localparam logic [3:0] ALU_SRA  = 4'h5;
   localparam logic [3:0] ALU_OR   = 4'h6;
   localparam logic [3:0] ALU_AND  = 4'h7;
   localparam logic [3:0] ALU_SLTU = 4'h8;
   localparam logic [3:0] ALU_BNE  = 4'h9;
   localparam logic [3:0] ALU_BEQ  = 4'hA;
   localparam logic [3:0] ALU_LUI  = 4'hB;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_W    = 3'b010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0]      alu_op;
      logic [XLEN-1:0] alu_a;
      logic [XLEN-1:0] alu_b;
      logic [XLEN-1:0] store_data;
      logic [4:0]      rd;
      logic            reg_we;
      logic            mem_rd;
      logic            mem_wr;
      logic            is_branch;
      logic            is_jump;
      logic [XLEN-1:0] target;
      logic            illegal;
   } bundle_t;

   localparam int BUNDLE_W = $bits(bundle_t);

endpackage

// File: rtl/rv32_alu_decode.sv
// rtl/rv32_alu_decode.sv - combinational RV32I instruction to ALU bundle decode
module rv32_alu_decode
   import alu_pkg::*;
(
   input  logic [31:0]         instr_i,
   input  logic [XLEN-1:0]     pc_i,
   input  logic [XLEN-1:0]     rs1_i,
   input  logic [XLEN-1:0]     rs2_i,
   output logic [BUNDLE_W-1:0] bundle_o
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            ill;
   bundle_t         d;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u  = {instr_i[31:12], 12'b0};
   assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

   always_comb begin
      d   = '0;
      ill = 1'b0;
      case (opcode)
         OPC_LUI: begin
            d.alu_op = ALU_LUI;
            d.alu_b  = imm_u;
            d.reg_we = 1'b1;
         end
         OPC_AUIPC: begin
            d.alu_a  = pc_i;
            d.alu_b  = imm_u;
            d.reg_we = 1'b1;
         end
         OPC_OP_IMM: begin
            d.alu_a  = rs1_i;
            d.alu_b  = imm_i;
            d.reg_we = 1'b1;
            case (funct3)
               F3_ADD:  d.alu_op = ALU_ADD;
               F3_XOR:  d.alu_op = ALU_XOR;
               F3_OR:   d.alu_op = ALU_OR;
               F3_AND:  d.alu_op = ALU_AND;
               F3_SLTU: d.alu_op = ALU_SLTU;
               F3_SLL, F3_SRL: begin
                  // Bit 30 picks arithmetic shift; every other slot bit must be zero.
                  d.alu_op = (funct3 == F3_SLL) ? ALU_SLL : (instr_i[30] ? ALU_SRA : ALU_SRL);
                  d.alu_b  = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                  ill      = |{instr_i[31], instr_i[29:25]};
               end
               default: ill = 1'b1;
            endcase
         end
         OPC_OP: begin
            d.alu_a  = rs1_i;
            d.alu_b  = rs2_i;
            d.reg_we = 1'b1;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  F3_ADD:  d.alu_op = ALU_ADD;
                  F3_SLL:  d.alu_op = ALU_SLL;
                  F3_XOR:  d.alu_op = ALU_XOR;
                  F3_SRL:  d.alu_op = ALU_SRL;
                  F3_OR:   d.alu_op = ALU_OR;
                  F3_AND:  d.alu_op = ALU_AND;
                  F3_SLTU: d.alu_op = ALU_SLTU;
                  default: ill = 1'b1;
               endcase
            end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
               d.alu_op = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == F3_SRL) begin
               d.alu_op = ALU_SRA;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_BRANCH: begin
            d.alu_a     = rs1_i;
            d.alu_b     = rs2_i;
            d.is_branch = 1'b1;
            d.target    = pc_i + imm_b;
            case (funct3)
               F3_BEQ:  d.alu_op = ALU_BEQ;
               F3_BNE:  d.alu_op = ALU_BNE;
               default: ill = 1'b1;
            endcase
         end
         OPC_JAL: begin
            d.alu_a   = pc_i;
            d.alu_b   = XLEN'(4);
            d.reg_we  = 1'b1;
            d.is_jump = 1'b1;
            d.target  = pc_i + imm_j;
         end
         OPC_LOAD: begin
            d.alu_a  = rs1_i;
            d.alu_b  = imm_i;
            d.mem_rd = 1'b1;
            d.reg_we = 1'b1;
            ill      = (funct3 != F3_W);
         end
         OPC_STORE: begin
            d.alu_a      = rs1_i;
            d.alu_b      = imm_s;
            d.mem_wr     = 1'b1;
            d.store_data = rs2_i;
            ill          = (funct3 != F3_W);
         end
         default: ill = 1'b1;
      endcase

      if (ill) begin
         d         = '0;
         d.illegal = 1'b1;
      end
      d.rd = d.reg_we ? instr_i[11:7] : 5'd0;
   end

   assign bundle_o = d;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID to EX issue stage with a registered 2-entry skid buffer
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [XLEN-1:0] store_data,
   output logic [4:0]      rd,
   output logic            reg_we,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            is_branch,
   output logic            is_jump,
   output logic [XLEN-1:0] target,
   output logic            illegal
);

   logic [BUNDLE_W-1:0] dec_bits;
   bundle_t             dec;
   bundle_t             out_q, out_d, skid_q, skid_d;
   logic                valid_q, valid_d, skid_valid_q, skid_valid_d;

   rv32_alu_decode u_decode (
      .instr_i  (in_instr),
      .pc_i     (in_pc),
      .rs1_i    (in_rs1),
      .rs2_i    (in_rs2),
      .bundle_o (dec_bits)
   );

   assign dec = bundle_t'(dec_bits);

   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      valid_d      = valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         valid_d      = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!valid_q || out_ready) begin
         // Output slot frees this edge: the older skid entry always goes first.
         if (skid_valid_q) begin
            out_d        = skid_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_valid) begin
            out_d   = dec;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end else if (in_valid && !skid_valid_q) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         valid_q      <= ~RESET_PC_INVALID;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         valid_q      <= valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign in_ready   = ~skid_valid_q;
   assign out_valid  = valid_q;
   assign alu_op     = out_q.alu_op;
   assign alu_a      = out_q.alu_a;
   assign alu_b      = out_q.alu_b;
   assign store_data = out_q.store_data;
   assign rd         = out_q.rd;
   assign reg_we     = out_q.reg_we;
   assign mem_rd     = out_q.mem_rd;
   assign mem_wr     = out_q.mem_wr;
   assign is_branch  = out_q.is_branch;
   assign is_jump    = out_q.is_jump;
   assign target     = out_q.target;
   assign illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - table-driven scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [31:0] in_instr = '0, in_pc = '0, in_rs1 = '0, in_rs2 = '0;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, store_data, target;
   logic [4:0]  rd;
   logic        reg_we, mem_rd, mem_wr, is_branch, is_jump, illegal;

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
      .rd(rd), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .is_branch(is_branch), .is_jump(is_jump), .target(target), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr, pc, rs1, rs2;
      bundle_t     exp;
   } vec_t;

   vec_t    vecs[$];
   bundle_t sb[$];
   bundle_t cur_exp;
   int      n_tests = 0, n_fail = 0;
   bit      last_acc;

   function automatic bundle_t mk(input logic [3:0] op, input logic [31:0] a, b, sd,
                                  input logic [4:0] r, input logic we, mr, mw, br, jp,
                                  input logic [31:0] tg, input logic il);
      bundle_t e;
      e = '{alu_op:op, alu_a:a, alu_b:b, store_data:sd, rd:r, reg_we:we, mem_rd:mr,
            mem_wr:mw, is_branch:br, is_jump:jp, target:tg, illegal:il};
      return e;
   endfunction

   function automatic bundle_t sample();
      return mk(alu_op, alu_a, alu_b, store_data, rd, reg_we, mem_rd, mem_wr,
                is_branch, is_jump, target, illegal);
   endfunction

   task automatic add(input logic [31:0] instr, pc, rs1, rs2, input bundle_t e);
      vec_t v;
      v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t v, input logic valid);
      in_instr = v.instr; in_pc = v.pc; in_rs1 = v.rs1; in_rs2 = v.rs2;
      in_valid = valid; cur_exp = v.exp;
   endtask

   // Called at a falling edge: checks occupancy, scores output transfer, records acceptance.
   task automatic tick();
      bundle_t e;
      chk("out_valid_occupancy", 256'(out_valid), 256'(sb.size() > 0));
      chk("in_ready_occupancy", 256'(in_ready), 256'(sb.size() < 2));
      last_acc = in_valid && in_ready && !flush;
      if (out_valid && out_ready && !flush) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 256'(sample()), 256'(0));
         end else begin
            e = sb.pop_front();
            chk("bundle", 256'(sample()), 256'(e));
         end
      end
      if (flush) sb.delete();
      if (last_acc) sb.push_back(cur_exp);
      @(negedge clk);
   endtask

   initial begin
      bundle_t held;
      vec_t    v;
      int      k;

      add(32'hFFF08293, 32'h0, 32'h10, 32'h0,
          mk(ALU_ADD, 32'h10, 32'hFFFFFFFF, 0, 5, 1, 0, 0, 0, 0, 0, 0));
      add(32'h4041D193, 32'h4, 32'h80000000, 32'h0,
          mk(ALU_SRA, 32'h80000000, 32'h4, 0, 3, 1, 0, 0, 0, 0, 0, 0));
      add(32'h40208033, 32'h8, 32'h30, 32'h7,
          mk(ALU_SUB, 32'h30, 32'h7, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      add(32'hFE209CE3, 32'h100, 32'h1, 32'h2,
          mk(ALU_BNE, 32'h1, 32'h2, 0, 0, 0, 0, 0, 1, 0, 32'hF8, 0));
      add(32'h0020A033, 32'h0, 32'h1, 32'h2, mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      add(32'h000100E7, 32'h0, 32'h1, 32'h2, mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      add(32'h123453B7, 32'h0, 32'h5, 32'h6,
          mk(ALU_LUI, 0, 32'h12345000, 0, 7, 1, 0, 0, 0, 0, 0, 0));
      add(32'h00001117, 32'h200, 32'h5, 32'h6,
          mk(ALU_ADD, 32'h200, 32'h1000, 0, 2, 1, 0, 0, 0, 0, 0, 0));
      add(32'h010000EF, 32'h40, 32'h5, 32'h6,
          mk(ALU_ADD, 32'h40, 32'h4, 0, 1, 1, 0, 0, 0, 1, 32'h50, 0));
      add(32'h00812203, 32'h0, 32'h1000, 32'h6,
          mk(ALU_ADD, 32'h1000, 32'h8, 0, 4, 1, 1, 0, 0, 0, 0, 0));
      add(32'hFE312E23, 32'h0, 32'h1000, 32'hDEADBEEF,
          mk(ALU_ADD, 32'h1000, 32'hFFFFFFFC, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 0));
      add(32'h0F00F313, 32'h0, 32'hABCD, 32'h0,
          mk(ALU_AND, 32'hABCD, 32'hF0, 0, 6, 1, 0, 0, 0, 0, 0, 0));
      add(32'h0010A093, 32'h0, 32'h1, 32'h0, mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      add(32'h02009093, 32'h0, 32'h1, 32'h0, mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      add(32'h00004063, 32'h0, 32'h1, 32'h0, mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      add(32'h0020E2B3, 32'h0, 32'h11, 32'h22,
          mk(ALU_OR, 32'h11, 32'h22, 0, 5, 1, 0, 0, 0, 0, 0, 0));
      add(32'h0020B2B3, 32'h0, 32'h11, 32'h22,
          mk(ALU_SLTU, 32'h11, 32'h22, 0, 5, 1, 0, 0, 0, 0, 0, 0));
      add(32'h00000013, 32'h0, 32'h9, 32'h0,
          mk(ALU_ADD, 32'h9, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      add(32'h00000073, 32'h0, 32'h9, 32'h0, mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      add(32'h02000063, 32'hFFFFFFF0, 32'h3, 32'h3,
          mk(ALU_BEQ, 32'h3, 32'h3, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0));

      repeat (2) @(negedge clk);
      chk("reset_out_valid", 256'(out_valid), 256'(0));
      chk("reset_in_ready", 256'(in_ready), 256'(1));
      chk("reset_bundle", 256'(sample()), 256'(0));
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back stream with the EX stage always ready.
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         drive(vecs[i], 1'b1);
         tick();
      end
      in_valid = 1'b0;
      repeat (2) tick();
      chk("stream_drained", 256'(sb.size()), 256'(0));

      // Backpressure: first held, second in skid, third waits upstream.
      out_ready = 1'b0;
      drive(vecs[0], 1'b1); tick();
      drive(vecs[3], 1'b1); tick();
      drive(vecs[6], 1'b1); tick();
      held = sample();
      tick();
      chk("held_stable", 256'(sample()), 256'(held));
      chk("held_is_first", 256'(sample()), 256'(vecs[0].exp));
      chk("third_not_taken", 256'(sb.size()), 256'(2));
      out_ready = 1'b1;
      last_acc = 1'b0;
      for (k = 0; k < 10 && !last_acc; k++) tick();
      chk("third_accepted", 256'(last_acc), 256'(1));
      in_valid = 1'b0;
      repeat (4) tick();
      chk("backpressure_drained", 256'(sb.size()), 256'(0));

      // Flush with the skid full and a new input offered in the same cycle.
      out_ready = 1'b0;
      drive(vecs[7], 1'b1); tick();
      drive(vecs[8], 1'b1); tick();
      chk("skid_full", 256'(in_ready), 256'(0));
      drive(vecs[9], 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 256'(out_valid), 256'(0));
      chk("flush_in_ready", 256'(in_ready), 256'(1));
      out_ready = 1'b1;
      repeat (3) tick();

      // Asynchronous reset mid-operation.
      out_ready = 1'b0;
      drive(vecs[10], 1'b1); tick();
      drive(vecs[11], 1'b1); tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midreset_out_valid", 256'(out_valid), 256'(0));
      chk("midreset_in_ready", 256'(in_ready), 256'(1));
      chk("midreset_bundle", 256'(sample()), 256'(0));
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      v = vecs[1];
      out_ready = 1'b1;
      drive(v, 1'b1); tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("final_drained", 256'(sb.size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID→EX producer for the ALU's 4-bit opcode interface.
- Accepts RV32I instructions with their PC and register-file read data on a valid/ready handshake.
- Decodes each instruction into an ALU opcode, operand A/B, and control flags.
- Presents the result through a registered 2-entry skid buffer to the EX stage.
- Supports downstream backpressure and pipeline flush.

Parameters:
XLEN, 32, datapath width of operands, PC and immediates.
RESET_PC_INVALID, 1, when 1 out_valid resets to 0 (fixed; not configurable to 0 in this revision).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  stage can accept an instruction this cycle.
in_instr  input  32  RV32I instruction word.
in_pc  input  XLEN  PC of in_instr.
in_rs1  input  XLEN  rs1 read data.
in_rs2  input  XLEN  rs2 read data.
flush  input  1  synchronous kill of all held and incoming instructions.
out_valid  output  1  EX bundle valid.
out_ready  input  1  EX accepts bundle.
alu_op  output  4  ALU opcode.
alu_a  output  XLEN  ALU operand A.
alu_b  output  XLEN  ALU operand B.
store_data  output  XLEN  rs2 value for SW.
rd  output  5  destination register.
reg_we  output  1  write rd.
mem_rd  output  1  LW.
mem_wr  output  1  SW.
is_branch  output  1  BEQ/BNE.
is_jump  output  1  JAL.
target  output  XLEN  branch/jump target.
illegal  output  1  unsupported encoding.

Behaviour:
- Reset (async, rst=1): out_valid=0, skid entry empty, in_ready=1. All bundle outputs = 0 (alu_op=ADD=4'b0000).
- ALU opcodes: ADD 0, SUB 1, SLL 2, XOR 3, SRL 4, SRA 5, OR 6, AND 7, SLTU 8, BNE 9, BEQ A, LUI B.
- Decode (combinational on input side):
  - LUI: op LUI, a=0, b=U-imm, reg_we.
  - AUIPC: ADD, a=pc, b=U-imm, reg_we.
  - OP-IMM:
    - ADDI→ADD; XORI→XOR; ORI→OR; ANDI→AND; SLTIU→SLTU (b=sign-extended I-imm).
    - SLLI→SLL, SRLI→SRL, SRAI→SRA selected by instr[30]; b={27'b0,shamt}.
    - Slot funct7 bits other than [30] nonzero → illegal. SLTI → illegal.
  - OP: funct7=0000000 → ADD/SLL/XOR/SRL/OR/AND/SLTU; funct7=0100000 with funct3 000/101 → SUB/SRA; SLT or any other funct7 → illegal.
  - BRANCH: funct3 000→BEQ, 001→BNE, others illegal; a=rs1, b=rs2, is_branch, target=pc+B-imm, reg_we=0.
  - JAL: ADD, a=pc, b=4, reg_we, is_jump, target=pc+J-imm.
  - LW: ADD, a=rs1, b=I-imm, mem_rd, reg_we. SW: ADD, a=rs1, b=S-imm, mem_wr, store_data=rs2. Other widths illegal.
  - Anything else (incl. JALR, SYSTEM, FENCE): illegal.
  - Illegal bundle: alu_op=ADD, reg_we=mem_rd=mem_wr=is_branch=is_jump=0, illegal=1. It still flows as a valid bundle.
  - rd forced to 0 when reg_we=0. Writes to x0 keep reg_we=1; the regfile ignores them.
- Latency: one cycle. A bundle accepted on edge N is visible with out_valid=1 after edge N.
- Handshake:
  - Transfer on in_valid&in_ready (input side) and on out_valid&out_ready (output side).
  - in_ready = ~skid_full, registered, with no combinational path from out_ready.
  - If the output is held (out_valid&~out_ready) and a new input is accepted, the input goes to the skid entry. in_ready drops the next cycle.
  - When the output drains, the skid entry moves to the output. in_ready rises the next cycle.
  - Outputs are stable while out_valid&~out_ready.
- Flush (sync): at the next edge out_valid=0 and the skid is emptied. Any input offered in the flush cycle is dropped, even if in_ready=1. flush has priority over every transfer.
- Reset mid-operation discards everything immediately.
- target and the immediate adds wrap modulo 2^XLEN.

Decomposition:
- alu_pkg: ALU opcode localparams (values above) and RV32I major opcode/funct3/funct7 constants.
- Sub-module rv32_alu_decode: purely combinational instruction → bundle.
- alu_issue_stage: the skid/pipeline registers and handshake.

Test Plan:
- After reset, drive ADDI x5,x1,-1 (0xFFF08293), rs1=0x10, out_ready=1 → next cycle out_valid=1, alu_op=0, a=0x10, b=0xFFFFFFFF, rd=5, reg_we=1.
- Drive SRAI x3,x3,4 (0x4041D193) then SUB (0x40208033) back-to-back → ops 5 (b=4) then 1 on consecutive cycles.
- BNE at pc=0x100 with offset -8 → alu_op=9, is_branch=1, reg_we=0, target=0x000000F8.
- Hold out_ready=0 and stream 3 instructions → first held stable, second in skid, in_ready=0. Third held upstream until drained; then all three emerge in order, none lost or duplicated.
- With skid full, assert flush for one cycle with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed input never appears.
- SLT (0x0020A033) and JALR → illegal=1, alu_op=0, reg_we=0, out_valid=1.
